dlk_buffer_ctrl: RTL and testbench

- Scheduler in front of the base-address circular buffer of the buffer-overflow detection unit.
- The buffer has one `base_addr` port shared by two operations: recording an allocation and looking up the bound of a checked access. They cannot happen in the same cycle.
- This block:
  - arbitrates allocation requesters against the load/store check requester;
  - sequences each operation into the buffer;
  - returns check results;
  - sequences the debug clear.

---
 rtl/dlk_pkg.sv | 22 ++
 rtl/dlk_rr_arb.sv | 42 ++++
 rtl/dlk_buffer_ctrl.sv | 124 ++++++++++++
 tb/tb_dlk_buffer_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlk_pkg.sv
// Shared types and constants for the base-address buffer scheduler.
package dlk_pkg;

  localparam int ADDR_W = 32;

  // Address 0 marks an empty buffer slot, so it can never be recorded.
  localparam logic [ADDR_W-1:0] DLK_EMPTY_ADDR = '0;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CHECK,
    CLEAR
  } dlk_ctrl_state_e;

  // Operands latched at the handshake and replayed to the buffer.
  typedef struct packed {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] addr;
  } dlk_op_t;

endpackage

// File: rtl/dlk_rr_arb.sv
// N-way round-robin arbiter; search starts one past the last accepted grant.
module dlk_rr_arb #(
  parameter  int N     = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N-1:0]     req_i,
  input  logic             accept_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_any_o
);

  localparam logic [IDX_W:0] NW = (IDX_W+1)'(N);

  logic [IDX_W-1:0] last_q;
  logic [IDX_W:0]   cand;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = last_q;
    gnt_any_o = 1'b0;
    cand      = '0;
    for (int i = 1; i <= N; i++) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(i);
      if (cand >= NW) cand = cand - NW;
      if (!gnt_any_o && req_i[cand[IDX_W-1:0]]) begin
        gnt_any_o                 = 1'b1;
        gnt_o[cand[IDX_W-1:0]]    = 1'b1;
        gnt_idx_o                 = cand[IDX_W-1:0];
      end
    end
  end

  // The pointer only moves on an actual handshake so a stalled grant keeps its turn.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                     last_q <= IDX_W'(N-1);
    else if (accept_i && gnt_any_o)  last_q <= gnt_idx_o;
  end

endmodule

// File: rtl/dlk_buffer_ctrl.sv
// Scheduler sharing the buffer base_addr port between allocation records,
// bound checks and the debug clear.
module dlk_buffer_ctrl
  import dlk_pkg::*;
#(
  parameter int NB_REQ = 2,
  parameter int CNT_W  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NB_REQ-1:0]              alloc_valid_i,
  input  logic [NB_REQ-1:0][ADDR_W-1:0]  alloc_addr_i,
  output logic [NB_REQ-1:0]              alloc_ready_o,
  input  logic                           chk_valid_i,
  input  logic [ADDR_W-1:0]              chk_base_i,
  input  logic [ADDR_W-1:0]              chk_addr_i,
  output logic                           chk_ready_o,
  output logic                           rsp_valid_o,
  output logic                           rsp_overflow_o,
  input  logic                           flush_i,
  output logic                           busy_o,
  output logic                           buf_en_write_o,
  output logic [ADDR_W-1:0]              buf_base_addr_o,
  output logic [ADDR_W-1:0]              buf_read_addr_o,
  input  logic                           buf_read_overflow_i,
  output logic                           buf_rst_us_o,
  output logic [CNT_W-1:0]               ovf_cnt_o
);

  localparam int IDX_W = (NB_REQ > 1) ? $clog2(NB_REQ) : 1;

  dlk_ctrl_state_e   state_q, state_d;
  dlk_op_t           op_q;
  logic              flush_pend_q, flush_pend_d;
  logic              last_chk_q;
  logic              rsp_valid_q, rsp_ovf_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept_ok, chk_win, alloc_win, chk_hs, alloc_hs;
  logic [NB_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_any;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_zero;

  dlk_rr_arb #(.N(NB_REQ)) u_alloc_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (alloc_valid_i),
    .accept_i  (alloc_hs),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .gnt_any_o (arb_any)
  );

  // rst_ni in the qualifier keeps every ready low while reset is held.
  assign accept_ok = (state_q == IDLE) && !flush_pend_q && rst_ni;
  assign chk_win   = chk_valid_i && (!arb_any || !last_chk_q);
  assign alloc_win = arb_any && !chk_win;
  assign chk_hs    = accept_ok && chk_win;
  assign alloc_hs  = accept_ok && alloc_win;

  assign sel_addr  = alloc_addr_i[arb_idx];
  assign sel_zero  = (sel_addr == DLK_EMPTY_ADDR);

  assign alloc_ready_o = alloc_hs ? arb_gnt : '0;
  assign chk_ready_o   = chk_hs;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q | flush_i;
    unique case (state_q)
      IDLE: begin
        if (flush_pend_q)               state_d = CLEAR;
        else if (chk_hs)                state_d = CHECK;
        else if (alloc_hs && !sel_zero) state_d = WRITE;
        else if (flush_i)               state_d = CLEAR;
      end
      WRITE, CHECK: state_d = (flush_pend_q || flush_i) ? CLEAR : IDLE;
      CLEAR:        state_d = IDLE;
      default:      state_d = IDLE;
    endcase
    // Entering CLEAR services every flush seen so far.
    if (state_d == CLEAR) flush_pend_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      last_chk_q   <= 1'b0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (chk_hs) begin
        op_q.base  <= chk_base_i;
        op_q.addr  <= chk_addr_i;
        last_chk_q <= 1'b1;
      end else if (alloc_hs) begin
        op_q.base  <= sel_addr;
        last_chk_q <= 1'b0;
      end
      rsp_valid_q <= (state_q == CHECK);
      rsp_ovf_q   <= (state_q == CHECK) && buf_read_overflow_i;
      // Counted as the result is registered so ovf_cnt_o moves with rsp_valid_o.
      if ((state_q == CHECK) && buf_read_overflow_i && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign buf_en_write_o  = (state_q == WRITE);
  assign buf_rst_us_o    = (state_q == CLEAR);
  assign buf_base_addr_o = ((state_q == WRITE) || (state_q == CHECK)) ? op_q.base : '0;
  assign buf_read_addr_o = (state_q == CHECK) ? op_q.addr : '0;
  assign busy_o          = (state_q != IDLE) || flush_pend_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_overflow_o  = rsp_ovf_q;
  assign ovf_cnt_o       = cnt_q;

endmodule

// File: tb/tb_dlk_buffer_ctrl.sv
// Directed scenarios plus a randomized run against an event-scheduling model.
module tb_dlk_buffer_ctrl;

  localparam int NB_REQ = 2;
  localparam int CNT_W  = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NB_REQ-1:0]      alloc_valid_i;
  logic [NB_REQ-1:0][31:0] alloc_addr_i;
  logic [NB_REQ-1:0]      alloc_ready_o;
  logic                   chk_valid_i;
  logic [31:0]            chk_base_i, chk_addr_i;
  logic                   chk_ready_o, rsp_valid_o, rsp_overflow_o;
  logic                   flush_i, busy_o, buf_en_write_o, buf_rst_us_o;
  logic [31:0]            buf_base_addr_o, buf_read_addr_o;
  logic                   buf_read_overflow_i;
  logic [CNT_W-1:0]       ovf_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  // Buffer stub: an access 0x100 or more past its base overflows.
  assign buf_read_overflow_i = (buf_read_addr_o - buf_base_addr_o) >= 32'h100;

  logic [71:0] obs_nc;
  assign obs_nc = {alloc_ready_o, chk_ready_o, rsp_valid_o, rsp_overflow_o, busy_o,
                   buf_en_write_o, buf_rst_us_o, buf_base_addr_o, buf_read_addr_o};

  dlk_buffer_ctrl #(.NB_REQ(NB_REQ), .CNT_W(CNT_W)) dut (
    .clk_i, .rst_ni, .alloc_valid_i, .alloc_addr_i, .alloc_ready_o,
    .chk_valid_i, .chk_base_i, .chk_addr_i, .chk_ready_o,
    .rsp_valid_o, .rsp_overflow_o, .flush_i, .busy_o,
    .buf_en_write_o, .buf_base_addr_o, .buf_read_addr_o,
    .buf_read_overflow_i, .buf_rst_us_o, .ovf_cnt_o
  );

  task automatic idle_inputs();
    alloc_valid_i = '0; alloc_addr_i = '0; chk_valid_i = 1'b0;
    chk_base_i = '0; chk_addr_i = '0; flush_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    alloc_valid_i = 2'b11; alloc_addr_i[0] = 32'h10; alloc_addr_i[1] = 32'h20;
    chk_valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (obs_nc !== 72'h0 || ovf_cnt_o !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h/%h expected all zero", obs_nc, ovf_cnt_o);
    end
    do_reset();
    @(negedge clk_i);
    n_vec++;
    if (obs_nc !== 72'h0 || ovf_cnt_o !== '0) begin
      n_err++; $display("FAIL reset_idle: got %h/%h expected all zero", obs_nc, ovf_cnt_o);
    end
  endtask

  task automatic test_single_alloc();
    do_reset();
    alloc_valid_i = 2'b01; alloc_addr_i[0] = 32'h8000_1000; alloc_addr_i[1] = 32'h5555;
    @(negedge clk_i);
    n_vec++;
    if (alloc_ready_o !== 2'b01) begin
      n_err++; $display("FAIL single_alloc_ready: got %b expected 01", alloc_ready_o);
    end
    next_cycle(); alloc_valid_i = '0;
    @(negedge clk_i);
    n_vec++;
    if (buf_en_write_o !== 1'b1 || buf_base_addr_o !== 32'h8000_1000) begin
      n_err++; $display("FAIL single_alloc_write: got en=%b addr=%h expected en=1 addr=80001000",
                        buf_en_write_o, buf_base_addr_o);
    end
    next_cycle(); @(negedge clk_i);
    n_vec++;
    if (busy_o !== 1'b0 || buf_en_write_o !== 1'b0 || buf_base_addr_o !== 32'h0) begin
      n_err++; $display("FAIL single_alloc_idle: got busy=%b en=%b addr=%h expected 0/0/0",
                        busy_o, buf_en_write_o, buf_base_addr_o);
    end
  endtask

  task automatic test_fairness();
    int exp_g[6] = '{2, 0, 2, 1, 2, 0};
    int got[$];
    do_reset();
    alloc_valid_i = 2'b11; alloc_addr_i[0] = 32'hA000; alloc_addr_i[1] = 32'hB000;
    chk_valid_i = 1'b1; chk_base_i = 32'h1000; chk_addr_i = 32'h1004;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (chk_ready_o) got.push_back(2);
      else if (alloc_ready_o == 2'b01) got.push_back(0);
      else if (alloc_ready_o == 2'b10) got.push_back(1);
      next_cycle();
    end
    idle_inputs();
    n_vec++;
    if (got.size() != 6) begin
      n_err++; $display("FAIL fairness_count: got %0d grants expected 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_vec++;
      if (got[i] != exp_g[i]) begin
        n_err++; $display("FAIL fairness_order[%0d]: got %0d expected %0d", i, got[i], exp_g[i]);
      end
    end
  endtask

  task automatic test_check_result();
    do_reset();
    chk_valid_i = 1'b1; chk_base_i = 32'h1000; chk_addr_i = 32'h1100;
    @(negedge clk_i);
    n_vec++;
    if (chk_ready_o !== 1'b1) begin
      n_err++; $display("FAIL check_ready: got %b expected 1", chk_ready_o);
    end
    next_cycle(); chk_valid_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (buf_base_addr_o !== 32'h1000 || buf_read_addr_o !== 32'h1100 || rsp_valid_o !== 1'b0) begin
      n_err++; $display("FAIL check_drive: got base=%h addr=%h rsp=%b expected 1000/1100/0",
                        buf_base_addr_o, buf_read_addr_o, rsp_valid_o);
    end
    next_cycle(); @(negedge clk_i);
    n_vec++;
    if (rsp_valid_o !== 1'b1 || rsp_overflow_o !== 1'b1) begin
      n_err++; $display("FAIL check_rsp: got v=%b ovf=%b expected 1/1", rsp_valid_o, rsp_overflow_o);
    end
    next_cycle(); @(negedge clk_i);
    n_vec++;
    if (rsp_valid_o !== 1'b0 || ovf_cnt_o !== 4'd1) begin
      n_err++; $display("FAIL check_cnt: got v=%b cnt=%0d expected 0/1", rsp_valid_o, ovf_cnt_o);
    end
  endtask

  task automatic test_flush_during_check();
    do_reset();
    chk_valid_i = 1'b1; chk_base_i = 32'h1000; chk_addr_i = 32'h1010;
    @(negedge clk_i);
    n_vec++;
    if (chk_ready_o !== 1'b1) begin
      n_err++; $display("FAIL flush_chk_ready: got %b expected 1", chk_ready_o);
    end
    next_cycle();
    chk_valid_i = 1'b0; flush_i = 1'b1; alloc_valid_i = 2'b01; alloc_addr_i[0] = 32'h3000;
    @(negedge clk_i);
    n_vec++;
    if (alloc_ready_o !== 2'b00) begin
      n_err++; $display("FAIL flush_chk_n1_ready: got %b expected 00", alloc_ready_o);
    end
    next_cycle(); flush_i = 1'b0;
    @(negedge clk_i);
    n_vec++;
    if (rsp_valid_o !== 1'b1 || rsp_overflow_o !== 1'b0 || buf_rst_us_o !== 1'b1 ||
        alloc_ready_o !== 2'b00) begin
      n_err++; $display("FAIL flush_chk_n2: got rsp=%b ovf=%b rst=%b rdy=%b expected 1/0/1/00",
                        rsp_valid_o, rsp_overflow_o, buf_rst_us_o, alloc_ready_o);
    end
    next_cycle(); @(negedge clk_i);
    n_vec++;
    if (alloc_ready_o !== 2'b01 || buf_rst_us_o !== 1'b0) begin
      n_err++; $display("FAIL flush_chk_n3: got rdy=%b rst=%b expected 01/0", alloc_ready_o, buf_rst_us_o);
    end
    next_cycle(); alloc_valid_i = '0;
    @(negedge clk_i);
    n_vec++;
    if (buf_en_write_o !== 1'b1 || buf_base_addr_o !== 32'h3000) begin
      n_err++; $display("FAIL flush_chk_write: got en=%b addr=%h expected 1/3000",
                        buf_en_write_o, buf_base_addr_o);
    end
  endtask

  task automatic test_flush_idle();
    do_reset();
    flush_i = 1'b1; alloc_valid_i = 2'b01; alloc_addr_i[0] = 32'h4000;
    @(negedge clk_i);
    n_vec++;
    if (alloc_ready_o !== 2'b01) begin
      n_err++; $display("FAIL flush_req_accept: got %b expected 01", alloc_ready_o);
    end
    next_cycle(); flush_i = 1'b0; alloc_valid_i = '0;
    @(negedge clk_i);
    n_vec++;
    if (buf_en_write_o !== 1'b1 || buf_rst_us_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++; $display("FAIL flush_req_write: got en=%b rst=%b busy=%b expected 1/0/1",
                        buf_en_write_o, buf_rst_us_o, busy_o);
    end
    next_cycle(); @(negedge clk_i);
    n_vec++;
    if (buf_rst_us_o !== 1'b1) begin
      n_err++; $display("FAIL flush_req_clear: got %b expected 1", buf_rst_us_o);
    end
    next_cycle(); flush_i = 1'b1;
    @(negedge clk_i);
    next_cycle(); flush_i = 1'b0; alloc_valid_i = 2'b10; alloc_addr_i[1] = 32'h4400;
    @(negedge clk_i);
    n_vec++;
    if (buf_rst_us_o !== 1'b1 || alloc_ready_o !== 2'b00) begin
      n_err++; $display("FAIL flush_idle_n1: got rst=%b rdy=%b expected 1/00", buf_rst_us_o, alloc_ready_o);
    end
    next_cycle(); @(negedge clk_i);
    n_vec++;
    if (alloc_ready_o !== 2'b10 || busy_o !== 1'b0) begin
      n_err++; $display("FAIL flush_idle_n2: got rdy=%b busy=%b expected 10/0", alloc_ready_o, busy_o);
    end
    next_cycle(); idle_inputs();
  endtask

  task automatic test_zero_addr();
    do_reset();
    alloc_valid_i = 2'b01; alloc_addr_i[0] = 32'h0; alloc_addr_i[1] = 32'h2000;
    @(negedge clk_i);
    n_vec++;
    if (alloc_ready_o !== 2'b01) begin
      n_err++; $display("FAIL zero_accept: got %b expected 01", alloc_ready_o);
    end
    next_cycle(); alloc_valid_i = 2'b11;
    @(negedge clk_i);
    n_vec++;
    if (buf_en_write_o !== 1'b0 || alloc_ready_o !== 2'b10) begin
      n_err++; $display("FAIL zero_next: got en=%b rdy=%b expected 0/10", buf_en_write_o, alloc_ready_o);
    end
    next_cycle(); alloc_valid_i = '0;
    @(negedge clk_i);
    n_vec++;
    if (buf_en_write_o !== 1'b1 || buf_base_addr_o !== 32'h2000) begin
      n_err++; $display("FAIL zero_write: got en=%b addr=%h expected 1/2000", buf_en_write_o, buf_base_addr_o);
    end
  endtask

  task automatic test_saturation();
    int hs = 0;
    int rsp = 0;
    do_reset();
    chk_valid_i = 1'b1; chk_base_i = 32'h1000; chk_addr_i = 32'h1200;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_i);
      if (chk_ready_o) hs++;
      if (rsp_valid_o && rsp_overflow_o) rsp++;
      next_cycle();
      if (hs == 20) chk_valid_i = 1'b0;
    end
    n_vec++;
    if (rsp != 20 || ovf_cnt_o !== 4'd15) begin
      n_err++; $display("FAIL saturation: got rsp=%0d cnt=%0d expected 20/15", rsp, ovf_cnt_o);
    end
    flush_i = 1'b1; next_cycle(); flush_i = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk_i);
    n_vec++;
    if (ovf_cnt_o !== 4'd15) begin
      n_err++; $display("FAIL cnt_after_flush: got %0d expected 15", ovf_cnt_o);
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    alloc_valid_i = 2'b01; alloc_addr_i[0] = 32'h6000;
    @(negedge clk_i);
    next_cycle();
    alloc_valid_i = 2'b11; alloc_addr_i[1] = 32'h7000; chk_valid_i = 1'b1;
    rst_ni = 1'b0; #1;
    n_vec++;
    if (obs_nc !== 72'h0 || ovf_cnt_o !== '0) begin
      n_err++; $display("FAIL reset_mid_write: got %h/%h expected all zero", obs_nc, ovf_cnt_o);
    end
    next_cycle(); rst_ni = 1'b1; idle_inputs();
    @(negedge clk_i);
    n_vec++;
    if (obs_nc !== 72'h0) begin
      n_err++; $display("FAIL reset_release: got %h expected all zero", obs_nc);
    end
  endtask

  // Model: per future cycle, which buffer operation is scheduled.
  task automatic test_random();
    bit          m_occ[4], m_isop[4], m_wr[4], m_ck[4], m_rst[4], m_rsp[4], m_rov[4];
    logic [31:0] m_wa[4], m_cb[4], m_ca[4];
    bit          m_pend = 0, m_last_chk = 0;
    int          m_last_gnt = NB_REQ - 1;
    int          m_cnt = 0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m_occ[k] = 0; m_isop[k] = 0; m_wr[k] = 0; m_ck[k] = 0; m_rst[k] = 0;
      m_rsp[k] = 0; m_rov[k] = 0; m_wa[k] = 0; m_cb[k] = 0; m_ca[k] = 0;
    end
    for (int t = 0; t < 600; t++) begin
      int s, n, n2, win, idx;
      logic [1:0]  e_ar;
      logic [71:0] exp_nc;
      bit op;
      next_cycle();
      alloc_valid_i   = 2'($urandom);
      alloc_addr_i[0] = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      alloc_addr_i[1] = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
      chk_valid_i     = $urandom_range(0, 1) == 1;
      chk_base_i      = $urandom & 32'hFFFF_FF00;
      chk_addr_i      = chk_base_i + $urandom_range(0, 32'h1FF);
      flush_i         = $urandom_range(0, 7) == 0;
      @(negedge clk_i);
      s = t % 4; n = (t + 1) % 4; n2 = (t + 2) % 4;
      win = 0; idx = 0; e_ar = '0;
      if (!m_occ[s] && !m_pend) begin
        if (chk_valid_i && (alloc_valid_i == '0 || !m_last_chk)) win = 2;
        else if (alloc_valid_i != '0) begin
          win = 1;
          for (int k = NB_REQ; k >= 1; k--)
            if (alloc_valid_i[(m_last_gnt + k) % NB_REQ]) idx = (m_last_gnt + k) % NB_REQ;
          e_ar[idx] = 1'b1;
        end
      end
      exp_nc = {e_ar, win == 2, m_rsp[s], m_rsp[s] & m_rov[s], m_occ[s] | m_pend,
                m_wr[s], m_rst[s], m_wr[s] ? m_wa[s] : (m_ck[s] ? m_cb[s] : 32'h0),
                m_ck[s] ? m_ca[s] : 32'h0};
      n_vec++;
      if (obs_nc !== exp_nc) begin
        n_err++; $display("FAIL random_outputs t=%0d: got %h expected %h", t, obs_nc, exp_nc);
      end
      if (!m_rsp[s]) begin
        n_vec++;
        if (ovf_cnt_o !== CNT_W'(m_cnt)) begin
          n_err++; $display("FAIL random_cnt t=%0d: got %0d expected %0d", t, ovf_cnt_o, m_cnt);
        end
      end
      // Advance the model past this cycle.
      if (m_occ[s]) begin
        if (m_isop[s] && (m_pend || flush_i)) begin
          m_occ[n] = 1; m_rst[n] = 1; m_pend = 0;
        end else if (flush_i) m_pend = 1;
      end else if (m_pend) begin
        m_occ[n] = 1; m_rst[n] = 1; m_pend = 0;
      end else begin
        op = 0;
        if (win == 2) begin
          m_occ[n] = 1; m_isop[n] = 1; m_ck[n] = 1; m_cb[n] = chk_base_i; m_ca[n] = chk_addr_i;
          m_rsp[n2] = 1; m_rov[n2] = (chk_addr_i - chk_base_i) >= 32'h100;
          m_last_chk = 1; op = 1;
        end else if (win == 1) begin
          m_last_gnt = idx; m_last_chk = 0;
          if (alloc_addr_i[idx] != 32'h0) begin
            m_occ[n] = 1; m_isop[n] = 1; m_wr[n] = 1; m_wa[n] = alloc_addr_i[idx]; op = 1;
          end
        end
        if (flush_i) begin
          if (op) m_pend = 1;
          else begin m_occ[n] = 1; m_rst[n] = 1; end
        end
      end
      if (m_rsp[s] && m_rov[s] && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      m_occ[s] = 0; m_isop[s] = 0; m_wr[s] = 0; m_ck[s] = 0; m_rst[s] = 0;
      m_rsp[s] = 0; m_rov[s] = 0;
    end
    next_cycle(); idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b1;
    test_reset();
    test_single_alloc();
    test_fairness();
    test_check_result();
    test_flush_during_check();
    test_flush_idle();
    test_zero_addr();
    test_saturation();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
